// File: rtl/cpu_bus_master.sv
// cpu_bus_master: turns one valid/ready command into a burst on a multiplexed 6800-style A/D bus.
// Latency: (5*N+1)*PHASE_TICKS+1 cycles from acceptance to rsp_valid, N = bytes in the burst.
// Backpressure: cmd_ready is high only in IDLE; rsp_valid is a one-cycle pulse that cannot be stalled.
module cpu_bus_master #(
  parameter int DATA_BYTES  = 2,
  parameter int PHASE_TICKS = 1,
  localparam int LEN_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1
) (
  input  logic                    XTAL_IN,
  input  logic                    RESET_N_IN,
  output logic                    E_IN,
  output logic                    RW,
  output logic                    AS,
  input  logic                    IRQ,
  inout  wire  [7:0]              DATA_ADDR_LOW,
  output logic [7:0]              AD_HIGH,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [15:0]             cmd_addr,
  input  logic [LEN_W-1:0]        cmd_len,
  input  logic [8*DATA_BYTES-1:0] cmd_wdata,
  output logic                    rsp_valid,
  output logic [8*DATA_BYTES-1:0] rsp_rdata,
  output logic                    irq_pending,
  input  logic                    irq_ack
);

  typedef enum logic [2:0] {IDLE, E_LOW, RW_SET, AS_HI, AS_LO, E_HI, END, DONE} state_t;

  localparam logic [LEN_W-1:0] LAST_BYTE = LEN_W'(DATA_BYTES - 1);
  localparam logic [3:0]       LAST_TICK = 4'(PHASE_TICKS - 1);

  state_t                  state_q, state_d;
  logic [3:0]              tick_q;
  logic [LEN_W-1:0]        idx_q, last_q, len_clamped;
  logic                    wr_q;
  logic [15:0]             addr_q, cur_addr;
  logic [8*DATA_BYTES-1:0] wdata_q, rbuf_q, rsp_q;
  logic [7:0]              ad_hold_q, bus_dout, wr_byte;
  logic                    bus_oe, ready_q, accept, tick_last;
  logic [LEN_W+2:0]        byte_sel;
  logic                    irq_s1_q, irq_s2_q, irq_pending_q;

  // ready_q keeps cmd_ready low during reset and for the release cycle
  assign cmd_ready   = ready_q && (state_q == IDLE);
  assign accept      = cmd_valid && cmd_ready;
  assign tick_last   = (tick_q == LAST_TICK);
  assign len_clamped = (int'(cmd_len) > DATA_BYTES - 1) ? LAST_BYTE : cmd_len;
  // full 16-bit increment so the carry reaches A[15:8] and 0xFFFF wraps to 0x0000
  assign cur_addr    = addr_q + {{(16 - LEN_W){1'b0}}, idx_q};
  assign byte_sel    = {idx_q, 3'b000};
  assign wr_byte     = wdata_q[byte_sel +: 8];
  assign rsp_rdata   = rsp_q;
  assign irq_pending = irq_pending_q;
  assign DATA_ADDR_LOW = bus_oe ? bus_dout : 8'hzz;

  // next state and Moore bus outputs
  always_comb begin
    state_d   = state_q;
    E_IN      = 1'b1;
    RW        = 1'b1;
    AS        = 1'b0;
    bus_oe    = 1'b0;
    bus_dout  = cur_addr[7:0];
    AD_HIGH   = ad_hold_q;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE:   if (accept) state_d = E_LOW;
      E_LOW: begin
        E_IN = 1'b0;
        // RW only changes in RW_SET; for later bytes of a write it is still low
        RW = !(wr_q && (idx_q != '0));
        if (tick_last) state_d = RW_SET;
      end
      RW_SET: begin
        E_IN = 1'b0;
        RW   = !wr_q;
        if (tick_last) state_d = AS_HI;
      end
      AS_HI: begin
        E_IN    = 1'b0;
        RW      = !wr_q;
        AS      = 1'b1;
        AD_HIGH = cur_addr[15:8];
        bus_oe  = 1'b1;
        if (tick_last) state_d = AS_LO;
      end
      AS_LO: begin
        E_IN   = 1'b0;
        RW     = !wr_q;
        bus_oe = 1'b1;
        if (tick_last) state_d = E_HI;
      end
      E_HI: begin
        RW       = !wr_q;
        bus_oe   = wr_q;
        bus_dout = wr_byte;
        if (tick_last) state_d = (idx_q == last_q) ? END : E_LOW;
      end
      END:    if (tick_last) state_d = DONE;
      DONE: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state register and per-phase tick counter
  always_ff @(posedge XTAL_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      state_q <= IDLE;
      tick_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      if (tick_last || state_q == IDLE || state_q == DONE) tick_q <= 4'd0;
      else                                                   tick_q <= tick_q + 4'd1;
    end
  end

  // latch the command on acceptance, advance the byte index and capture read bytes
  always_ff @(posedge XTAL_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      wr_q    <= 1'b0;
      addr_q  <= 16'h0000;
      last_q  <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
    end else if (accept) begin
      wr_q    <= cmd_write;
      addr_q  <= cmd_addr;
      last_q  <= len_clamped;
      idx_q   <= '0;
      wdata_q <= cmd_wdata;
      rbuf_q  <= '0;
    end else if (state_q == E_HI && tick_last) begin
      if (!wr_q)           rbuf_q[byte_sel +: 8] <= DATA_ADDR_LOW;
      if (idx_q != last_q) idx_q <= idx_q + LEN_W'(1);
    end
  end

  // response register, held high address byte and post-reset ready enable
  always_ff @(posedge XTAL_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      rsp_q     <= '0;
      ad_hold_q <= 8'h00;
      ready_q   <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (state_q == AS_HI) ad_hold_q <= cur_addr[15:8];
      // reads publish the whole buffer at once so rsp_rdata never shows a half-built value
      if (state_q == END && tick_last && !wr_q) rsp_q <= rbuf_q;
    end
  end

  // IRQ synchroniser and sticky pending flag; a new request beats a simultaneous ack
  always_ff @(posedge XTAL_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      irq_s1_q      <= 1'b1;
      irq_s2_q      <= 1'b1;
      irq_pending_q <= 1'b0;
    end else begin
      irq_s1_q <= IRQ;
      irq_s2_q <= irq_s1_q;
      if (!irq_s2_q)    irq_pending_q <= 1'b1;
      else if (irq_ack) irq_pending_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_bus_master.sv
// tb_cpu_bus_master: directed and random bursts on two instances (2 bytes/1 tick and 3 bytes/3 ticks).
// Expected bus activity comes from a phase timeline computed per cycle from the burst rules.
// The bench plays the bus slave and drives a random pattern whenever the master must float.
module tb_cpu_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  cmd_valid;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [1:0]  cmd_len;
  logic [23:0] cmd_wdata;
  logic        irq, irq_ack;
  logic [1:0]  e_in, rw, as_o, cmd_ready, rsp_valid, irq_pending;
  logic [7:0]  ad_high [2];
  logic [15:0] rsp0;
  logic [23:0] rsp1;
  wire  [7:0]  bus0, bus1;
  logic [1:0]  drv_en;
  logic [7:0]  drv_dat;
  logic [31:0] exp_rsp [2];

  int vectors = 0;
  int miscompares = 0;

  assign bus0 = drv_en[0] ? drv_dat : 8'hzz;
  assign bus1 = drv_en[1] ? drv_dat : 8'hzz;

  cpu_bus_master #(.DATA_BYTES(2), .PHASE_TICKS(1)) u_dut0 (
    .XTAL_IN(clk), .RESET_N_IN(rst_n), .E_IN(e_in[0]), .RW(rw[0]), .AS(as_o[0]),
    .IRQ(irq), .DATA_ADDR_LOW(bus0), .AD_HIGH(ad_high[0]),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len[0:0]), .cmd_wdata(cmd_wdata[15:0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp0), .irq_pending(irq_pending[0]), .irq_ack(irq_ack));

  cpu_bus_master #(.DATA_BYTES(3), .PHASE_TICKS(3)) u_dut1 (
    .XTAL_IN(clk), .RESET_N_IN(rst_n), .E_IN(e_in[1]), .RW(rw[1]), .AS(as_o[1]),
    .IRQ(irq), .DATA_ADDR_LOW(bus1), .AD_HIGH(ad_high[1]),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp1), .irq_pending(irq_pending[1]), .irq_ack(irq_ack));

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bus_of(input int k);
    return (k == 1) ? bus1 : bus0;
  endfunction

  function automatic logic [31:0] rsp_of(input int k);
    return (k == 1) ? {8'h00, rsp1} : {16'h0000, rsp0};
  endfunction

  task automatic chk_reset_vals(input int k);
    chk("rst_e_in",    e_in[k], 1'b1);
    chk("rst_rw",      rw[k], 1'b1);
    chk("rst_as",      as_o[k], 1'b0);
    chk("rst_ad_high", ad_high[k], 8'h00);
    chk("rst_bus_hiz", bus_of(k), drv_dat);
    chk("rst_ready",   cmd_ready[k], 1'b0);
    chk("rst_rvalid",  rsp_valid[k], 1'b0);
    chk("rst_rdata",   rsp_of(k), 32'h0);
    chk("rst_irq",     irq_pending[k], 1'b0);
  endtask

  // One burst on instance k, called and returning at a negedge.
  // exp_wait < 0 skips the acceptance-delay check, exp_lat < 0 uses the latency formula,
  // abort_c >= 0 pulses reset in that cycle after acceptance.
  task automatic run(input int k, input bit wr, input logic [15:0] addr, input logic [1:0] len,
                     input logic [31:0] wdata, input logic [31:0] rdata, input bit keep,
                     input int abort_c, input int exp_wait, input int exp_lat);
    int ticks, nbytes, cdone, waits, seen, b, sub, p;
    logic [15:0] ai;
    ticks  = (k == 1) ? 3 : 1;
    nbytes = (int'(len) > ((k == 1) ? 2 : 1)) ? ((k == 1) ? 3 : 2) : int'(len) + 1;
    cdone  = (5 * nbytes + 1) * ticks;
    if (exp_lat < 0) exp_lat = cdone + 1;
    if (!wr) begin
      exp_rsp[k] = 32'h0;
      for (int i = 0; i < nbytes; i++) exp_rsp[k][8*i +: 8] = rdata[8*i +: 8];
    end
    cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_wdata = wdata[23:0];
    cmd_valid[k] = 1'b1;
    waits = 0;
    while (cmd_ready[k] !== 1'b1 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    chk("cmd_ready_accept", cmd_ready[k], 1'b1);
    if (exp_wait >= 0) chk("accept_wait", waits, exp_wait);
    @(posedge clk); #1;
    if (!keep) cmd_valid[k] = 1'b0;
    // the master must ignore command fields after acceptance
    cmd_write = 1'($urandom); cmd_addr = 16'($urandom); cmd_len = 2'($urandom); cmd_wdata = 24'($urandom);
    seen = -1;
    for (int c = 0; c <= cdone; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      b = 0; sub = 5;
      if (c < 5 * nbytes * ticks) begin p = c / ticks; b = p / 5; sub = p % 5; end
      else if (c == cdone) sub = 6;
      ai = addr + 16'(b);
      drv_en[k] = !(sub == 2 || sub == 3 || (sub == 4 && wr));
      drv_dat   = (sub == 4) ? rdata[8*b +: 8] : 8'($urandom);
      @(negedge clk);
      if (rsp_valid[k] === 1'b1 && seen < 0) seen = c;
      chk("rsp_valid", rsp_valid[k], (sub == 6));
      chk("cmd_ready_busy", cmd_ready[k], 1'b0);
      chk("as", as_o[k], (sub == 2));
      if (sub == 0) chk("e_low", e_in[k], 1'b0);
      if (sub == 4) chk("e_hi", e_in[k], 1'b1);
      if (sub >= 1 && sub <= 4) chk("rw_burst", rw[k], !wr);
      if (sub == 5) chk("rw_end", rw[k], 1'b1);
      if (sub == 2 || sub == 3) chk("ad_high", ad_high[k], ai[15:8]);
      if (drv_en[k])      chk("bus_float", bus_of(k), drv_dat);
      else if (sub == 4)  chk("bus_wdata", bus_of(k), wdata[8*b +: 8]);
      else                chk("bus_addr", bus_of(k), ai[7:0]);
      if (sub == 6) chk("rsp_rdata", rsp_of(k), exp_rsp[k]);
      if (c == abort_c) begin
        drv_en = 2'b11; drv_dat = 8'h3C;
        cmd_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        exp_rsp[0] = 32'h0; exp_rsp[1] = 32'h0;
        chk_reset_vals(k);
        @(posedge clk); #1;
        chk("rst_hold_e", e_in[k], 1'b1);
        chk("rst_hold_ad", ad_high[k], 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_at_release", cmd_ready[k], 1'b0);
        @(posedge clk); #1;
        chk("ready_after_release", cmd_ready[k], 1'b1);
        for (int i = 0; i < 12; i++) begin
          @(negedge clk);
          chk("no_rsp_after_abort", rsp_valid[k], 1'b0);
          chk("no_replay", as_o[k], 1'b0);
        end
        return;
      end
    end
    chk("latency", seen + 1, exp_lat);
    drv_en[k] = 1'b1;
  endtask

  initial begin
    int k, gap;
    bit wr;
    logic [1:0] len;
    rst_n = 1'b0; cmd_valid = 2'b00; cmd_write = 1'b0; cmd_addr = 16'h0; cmd_len = 2'd0;
    cmd_wdata = 24'h0; irq = 1'b1; irq_ack = 1'b0; drv_en = 2'b11; drv_dat = 8'h96;
    exp_rsp[0] = 32'h0; exp_rsp[1] = 32'h0;
    #2;
    chk_reset_vals(0);
    chk_reset_vals(1);
    @(posedge clk); #1;
    chk("rst_hold_ready", cmd_ready[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_release0", cmd_ready[0], 1'b0);
    @(posedge clk); #1;
    chk("ready_first_clk0", cmd_ready[0], 1'b1);
    chk("ready_first_clk1", cmd_ready[1], 1'b1);
    @(negedge clk);

    // write 0x12FF, 2 bytes: address carries into A[15:8] for byte 1
    run(0, 1'b1, 16'h12FF, 2'd1, 32'h0000BEEF, 32'h0, 1'b0, -1, 0, 12);
    // single-byte read, slave returns 0x5A
    run(0, 1'b0, 16'h4000, 2'd0, 32'h0, 32'h0000005A, 1'b0, -1, 1, 7);
    // 3-tick phases, 2-byte read wrapping 0xFFFF -> 0x0000
    run(1, 1'b0, 16'hFFFF, 2'd1, 32'h0, 32'h0000C3A7, 1'b0, -1, -1, 34);
    // length 3 on a 3-byte master clamps to 3 bytes
    run(1, 1'b0, 16'h8000, 2'd3, 32'h0, 32'hEE112233, 1'b0, -1, -1, 49);
    run(1, 1'b1, 16'h00FE, 2'd3, 32'h00A1B2C3, 32'h0, 1'b0, -1, -1, 49);
    // cmd_valid held across two commands; second accepted in the IDLE cycle after DONE
    run(0, 1'b1, 16'h2233, 2'd1, 32'h00001234, 32'h0, 1'b1, -1, 0, 12);
    run(0, 1'b0, 16'h7FFF, 2'd1, 32'h0, 32'h00009876, 1'b0, -1, 1, 12);

    for (int i = 0; i < 20; i++) begin
      k   = int'($urandom_range(0, 1));
      wr  = 1'($urandom);
      len = (k == 1) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 1));
      run(k, wr, 16'($urandom), len, $urandom, $urandom, 1'b0, -1, -1, -1);
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
    end

    // reset during byte 1 E_HI of a write
    run(0, 1'b1, 16'h5550, 2'd1, 32'h0000CAFE, 32'h0, 1'b0, 9, -1, -1);

    // 1-cycle IRQ pulse; ack coincides with the synchronised request and loses
    irq = 1'b0;
    @(posedge clk); @(negedge clk);
    irq = 1'b1;
    chk("irq_not_yet", irq_pending[0], 1'b0);
    @(posedge clk); #1;
    irq_ack = 1'b1;
    chk("irq_sync_delay", irq_pending[0], 1'b0);
    @(posedge clk); #1;
    irq_ack = 1'b0;
    chk("irq_set_wins0", irq_pending[0], 1'b1);
    chk("irq_set_wins1", irq_pending[1], 1'b1);
    @(posedge clk); #1;
    chk("irq_sticky", irq_pending[0], 1'b1);
    irq_ack = 1'b1;
    @(posedge clk); #1;
    irq_ack = 1'b0;
    chk("irq_cleared0", irq_pending[0], 1'b0);
    chk("irq_cleared1", irq_pending[1], 1'b0);
    @(negedge clk);

    // normal operation after the aborted burst
    run(0, 1'b0, 16'hA0A0, 2'd1, 32'h0, 32'h00004321, 1'b0, -1, 0, 12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
